// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Multi-cycle 32-bit radix-2 restoring divider for MIPS DIV/DIVU.
//            Returns {remainder, quotient} for HI/LO, stalls the pipeline
//            while busy, and can be cancelled by a pipeline flush.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        annul_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    localparam logic [5:0] c_LAST_STEP = 6'd31;

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_work;      // {rem[32:0], quo[31:0]}
    logic [31:0] r_divisor;   // divisor magnitude
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_result;

    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [64:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [64:0] w_step;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_accept = start_i & ~annul_i;

    // Two's-complement magnitudes are only taken in signed mode; the most
    // negative value maps onto itself, which is correct as an unsigned magnitude.
    assign w_abs_a = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign w_abs_b = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // One restoring step: shift, trial-subtract, keep the difference if it fits.
    assign w_shift = r_work << 1;
    assign w_ge    = (w_shift[64:32] >= {1'b0, r_divisor});
    assign w_diff  = w_shift[64:32] - {1'b0, r_divisor};
    assign w_step  = w_ge ? {w_diff, w_shift[31:1], 1'b1} : w_shift;

    // Sign fix-ups applied to the value produced by the final step.
    assign w_quo_fix = r_neg_q ? (~w_step[31:0]  + 32'd1) : w_step[31:0];
    assign w_rem_fix = r_neg_r ? (~w_step[63:32] + 32'd1) : w_step[63:32];

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a flush outside IDLE always wins over completion.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (opdata2_i == 32'd0) ? S_DIVZERO : S_ON;
                end
            end
            S_DIVZERO: begin
                w_next_state = annul_i ? S_IDLE : S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == c_LAST_STEP) begin
                    w_next_state = S_END;
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and registered result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= 6'd0;
                        r_work    <= {33'd0, w_abs_a};
                        r_divisor <= w_abs_b;
                        r_neg_q   <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                        r_neg_r   <= signed_i & opdata1_i[31];
                    end
                end
                S_DIVZERO: begin
                    r_result <= 64'd0;
                end
                S_ON: begin
                    if (annul_i) begin
                        r_result <= 64'd0;
                        r_cnt    <= 6'd0;
                    end else begin
                        r_work <= w_step;
                        r_cnt  <= r_cnt + 6'd1;
                        if (r_cnt == c_LAST_STEP) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                S_END: begin
                    if (annul_i) begin
                        r_result <= 64'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = (r_state == S_END);
    assign stall_o  = ((r_state == S_IDLE) & w_accept) |
                      (r_state == S_DIVZERO) |
                      (r_state == S_ON);

endmodule
`default_nettype wire
